countdown_timer: RTL and testbench

- Seconds-resolution down-counter that produces timer_out for traffic_light_controller.
- Driven by the controller's timer_en, timer_load and timer_init outputs.
- Divides the system clock into 1 s ticks with an internal prescaler.
- Holds, loads, pauses and counts to zero, then flags expiry so the controller's FSM can advance phases.

---
 rtl/countdown_timer_pkg.sv | 40 ++++
 rtl/countdown_timer_second_prescaler.sv | 57 +++++
 rtl/countdown_timer.sv | 116 +++++++++++
 tb/tb_countdown_timer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the traffic-light controller and its countdown timer.
// Both blocks import this package so light, pedestrian and timer-state
// encodings have a single source of truth.
package countdown_timer_pkg;

  // Width of timer_init / timer_out (seconds).
  localparam int TIMER_W = 4;

  // Timer FSM states.
  //   TMR_IDLE : never loaded since reset
  //   TMR_RUN  : loaded and remaining seconds > 0
  //   TMR_DONE : loaded and remaining seconds == 0
  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_RUN  = 2'd1,
    TMR_DONE = 2'd2
  } tmr_state_e;

  // Vehicle light encodings used by traffic_light_controller.
  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2
  } light_e;

  // Pedestrian crossing permissions used by traffic_light_controller.
  typedef enum logic [1:0] {
    PED_NEITHER = 2'd0,
    PED_NS      = 2'd1,
    PED_EW      = 2'd2,
    PED_BOTH    = 2'd3
  } ped_e;

  // A load of a non-zero value starts a run; a load of zero lands directly
  // in DONE without ever producing an expiry pulse.
  function automatic tmr_state_e state_after_load(input logic init_nonzero);
    return init_nonzero ? TMR_RUN : TMR_DONE;
  endfunction

endpackage

// File: rtl/countdown_timer_second_prescaler.sv
// second_prescaler: divides clk into one pulse per TICKS_PER_SEC cycles.
//
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset (count -> 0)
//   clear_i  : force count to 0 on the next edge (wins over enable_i)
//   enable_i : advance the count this cycle; when low the count holds
//   wrap_o   : high in the cycle whose rising edge wraps the count to 0,
//              so the parent can register its own pulse on that same edge
//   count_o  : current prescaler value (debug visibility)
module second_prescaler #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int PRESCALE_W    = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  enable_i,
  output logic                  wrap_o,
  output logic [PRESCALE_W-1:0] count_o
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;
  logic                  at_last;

  assign at_last = (count_q == LAST);

  // wrap_o is a decision for the upcoming edge, not a registered output;
  // the parent registers sec_tick from it.
  assign wrap_o  = enable_i && !clear_i && at_last;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      if (at_last) begin
        count_d = '0;
      end else begin
        count_d = count_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: seconds-resolution down-counter for
// traffic_light_controller. An internal prescaler turns clk into 1 s ticks;
// each tick while running removes one second, and reaching zero raises a
// one-cycle timer_expired pulse so the controller can advance its phase.
//
// Ports:
//   clk           : system clock
//   rst           : synchronous active-high reset
//   timer_en      : 1 = count, 0 = pause (prescaler and count hold)
//   timer_load    : 1 = load timer_init on this edge (beats timer_en)
//   timer_init    : value to load, in seconds
//   timer_out     : registered remaining seconds
//   timer_expired : registered one-cycle pulse when a decrement reaches 0
//   sec_tick      : registered one-cycle pulse on each prescaler wrap
//   state_o       : current FSM state (debug)
//   prescale_o    : current prescaler value (debug)
//
// Control semantics: there is no handshake. Inputs are sampled on every
// rising edge with priority rst > timer_load > timer_en > hold; all outputs
// are registers, so nothing combinational reaches an output.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int PRESCALE_W    = 27,
  parameter int TIMER_W       = countdown_timer_pkg::TIMER_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  timer_en,
  input  logic                  timer_load,
  input  logic [TIMER_W-1:0]    timer_init,
  output logic [TIMER_W-1:0]    timer_out,
  output logic                  timer_expired,
  output logic                  sec_tick,
  output tmr_state_e            state_o,
  output logic [PRESCALE_W-1:0] prescale_o
);

  tmr_state_e         state_q,   state_d;
  logic [TIMER_W-1:0] timer_q,   timer_d;
  logic               expired_q, expired_d;
  logic               tick_q,    tick_d;

  logic               pre_enable;
  logic               pre_wrap;

  // The prescaler only runs while a non-zero count is live. In IDLE/DONE it
  // stays frozen at 0 (it is 0 after reset, after a load, and right after
  // the expiring wrap), so a later load always starts a full second.
  assign pre_enable = timer_en && !timer_load && (state_q == TMR_RUN);

  second_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .PRESCALE_W    (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_load),
    .enable_i (pre_enable),
    .wrap_o   (pre_wrap),
    .count_o  (prescale_o)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    expired_d = 1'b0;
    tick_d    = 1'b0;

    if (timer_load) begin
      timer_d = timer_init;
      state_d = state_after_load(timer_init != '0);
    end else begin
      case (state_q)
        TMR_RUN: begin
          // pre_wrap already implies timer_en and no load.
          if (pre_wrap) begin
            tick_d  = 1'b1;
            timer_d = timer_q - TIMER_W'(1);
            if (timer_q == TIMER_W'(1)) begin
              expired_d = 1'b1;
              state_d   = TMR_DONE;
            end
          end
        end
        TMR_IDLE, TMR_DONE: begin
          // Parked at zero: no wrap-around below 0, no pulses.
        end
        default: begin
          state_d = TMR_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TMR_IDLE;
      timer_q   <= '0;
      expired_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      expired_q <= expired_d;
      tick_q    <= tick_d;
    end
  end

  assign timer_out     = timer_q;
  assign timer_expired = expired_q;
  assign sec_tick      = tick_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
  import countdown_timer_pkg::*;

  localparam int T  = 4;
  localparam int W  = 4;
  localparam int PW = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          timer_en = 1'b0;
  logic          timer_load = 1'b0;
  logic [W-1:0]  timer_init = '0;
  logic [W-1:0]  timer_out;
  logic          timer_expired;
  logic          sec_tick;
  tmr_state_e    state_o;
  logic [PW-1:0] prescale_o;

  always #5 clk = ~clk;

  countdown_timer #(
    .TICKS_PER_SEC (T),
    .PRESCALE_W    (PW),
    .TIMER_W       (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .timer_en      (timer_en),
    .timer_load    (timer_load),
    .timer_init    (timer_init),
    .timer_out     (timer_out),
    .timer_expired (timer_expired),
    .sec_tick      (sec_tick),
    .state_o       (state_o),
    .prescale_o    (prescale_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // Seconds remaining, cycles elapsed in the current second, and whether
  // anything was ever loaded since reset.
  int m_secs;
  int m_elapsed;
  bit m_loaded;
  bit m_exp;
  bit m_tick;

  function automatic tmr_state_e model_state();
    if (!m_loaded) return TMR_IDLE;
    return (m_secs != 0) ? TMR_RUN : TMR_DONE;
  endfunction

  task automatic model_edge(input bit r, input bit l, input bit e, input int init);
    m_exp  = 0;
    m_tick = 0;
    if (r) begin
      m_secs = 0; m_elapsed = 0; m_loaded = 0;
    end else if (l) begin
      m_secs = init; m_elapsed = 0; m_loaded = 1;
    end else if (e && m_loaded && m_secs > 0) begin
      m_elapsed = m_elapsed + 1;
      if (m_elapsed == T) begin
        m_elapsed = 0;
        m_secs    = m_secs - 1;
        m_tick    = 1;
        m_exp     = (m_secs == 0);
      end
    end
  endtask

  // ---------------- driver ----------------
  // Drives inputs for one edge, advances the model, and returns #1 after
  // the edge so outputs can be sampled away from it.
  task automatic tick(input bit r, input bit l, input bit e, input logic [W-1:0] init);
    rst = r; timer_load = l; timer_en = e; timer_init = init;
    @(posedge clk);
    model_edge(r, l, e, int'(init));
    #1;
  endtask

  task automatic do_reset();
    tick(1, 0, 0, '0);
    tick(1, 0, 0, '0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (timer_out !== 4'd0 || timer_expired !== 1'b0 || sec_tick !== 1'b0 ||
        state_o !== TMR_IDLE || prescale_o !== 3'd0)
      $display("FAIL reset_state: out=%0d exp=%b tick=%b st=%0d pre=%0d, want 0 0 0 IDLE 0",
               timer_out, timer_expired, sec_tick, state_o, prescale_o);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 1, 4'(i));
      n_checks++;
      if (timer_out !== 4'd0 || timer_expired !== 1'b0 || sec_tick !== 1'b0 ||
          state_o !== TMR_IDLE || prescale_o !== 3'd0)
        $display("FAIL idle_hold cyc %0d: out=%0d exp=%b tick=%b st=%0d pre=%0d", i,
                 timer_out, timer_expired, sec_tick, state_o, prescale_o);
      else n_pass++;
    end
  endtask

  task automatic test_count();
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_hit[$];
    do_reset();
    tick(0, 1, 0, 4'd3);
    exp_q = '{8'd4, 8'd8, 8'd12};
    for (int e = 1; e <= 18; e++) begin
      tick(0, 0, 1, 4'd9);
      if (sec_tick) got_q.push_back(8'(e));
      if (timer_expired) exp_hit.push_back(8'(e));
      n_checks++;
      if (timer_out !== W'(m_secs) || sec_tick !== m_tick || timer_expired !== m_exp)
        $display("FAIL count3 edge %0d: out=%0d tick=%b exp=%b, want %0d %b %b", e,
                 timer_out, sec_tick, timer_expired, m_secs, m_tick, m_exp);
      else n_pass++;
    end
    n_checks++;
    if (got_q != exp_q)
      $display("FAIL count3_tick_edges: got %p, want %p", got_q, exp_q);
    else n_pass++;
    n_checks++;
    if (exp_hit.size() != 1 || exp_hit[0] !== 8'd12)
      $display("FAIL count3_expiry_edges: got %p, want '{12}", exp_hit);
    else n_pass++;
    n_checks++;
    if (timer_out !== 4'd0 || state_o !== TMR_DONE || prescale_o !== 3'd0)
      $display("FAIL count3_done: out=%0d st=%0d pre=%0d, want 0 DONE 0",
               timer_out, state_o, prescale_o);
    else n_pass++;
  endtask

  task automatic test_pause();
    do_reset();
    tick(0, 1, 0, 4'd2);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, 4'd0);
    n_checks++;
    if (timer_out !== 4'd1 || prescale_o !== 3'd2)
      $display("FAIL pause_entry: out=%0d pre=%0d, want 1 2", timer_out, prescale_o);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 4'(i));
      n_checks++;
      if (timer_out !== 4'd1 || prescale_o !== 3'd2 || sec_tick !== 1'b0 ||
          timer_expired !== 1'b0 || state_o !== TMR_RUN)
        $display("FAIL pause_hold cyc %0d: out=%0d pre=%0d tick=%b exp=%b st=%0d", i,
                 timer_out, prescale_o, sec_tick, timer_expired, state_o);
      else n_pass++;
    end
    tick(0, 0, 1, 4'd0);
    n_checks++;
    if (timer_out !== 4'd1 || timer_expired !== 1'b0)
      $display("FAIL resume_1: out=%0d exp=%b, want 1 0", timer_out, timer_expired);
    else n_pass++;
    tick(0, 0, 1, 4'd0);
    n_checks++;
    if (timer_out !== 4'd0 || timer_expired !== 1'b1 || sec_tick !== 1'b1)
      $display("FAIL resume_2: out=%0d exp=%b tick=%b, want 0 1 1",
               timer_out, timer_expired, sec_tick);
    else n_pass++;
    tick(0, 0, 1, 4'd0);
    n_checks++;
    if (timer_expired !== 1'b0 || timer_out !== 4'd0)
      $display("FAIL expiry_one_cycle: out=%0d exp=%b, want 0 0", timer_out, timer_expired);
    else n_pass++;
  endtask

  task automatic test_load_priority();
    do_reset();
    tick(0, 1, 0, 4'd5);
    for (int i = 0; i < T - 1; i++) tick(0, 0, 1, 4'd5);
    // Prescaler is now at T-1: the next counting edge would wrap.
    tick(0, 1, 1, 4'd9);
    n_checks++;
    if (timer_out !== 4'd9 || prescale_o !== 3'd0 || sec_tick !== 1'b0 ||
        timer_expired !== 1'b0)
      $display("FAIL load_vs_wrap: out=%0d pre=%0d tick=%b exp=%b, want 9 0 0 0",
               timer_out, prescale_o, sec_tick, timer_expired);
    else n_pass++;
    tick(0, 0, 1, 4'd1);
    n_checks++;
    if (timer_out !== 4'd9 || prescale_o !== 3'd1)
      $display("FAIL after_priority_load: out=%0d pre=%0d, want 9 1", timer_out, prescale_o);
    else n_pass++;
  endtask

  task automatic test_load_zero();
    do_reset();
    tick(0, 1, 1, 4'd0);
    n_checks++;
    if (timer_out !== 4'd0 || timer_expired !== 1'b0 || state_o !== TMR_DONE)
      $display("FAIL load_zero: out=%0d exp=%b st=%0d, want 0 0 DONE",
               timer_out, timer_expired, state_o);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 1, 4'd15);
      n_checks++;
      if (timer_out !== 4'd15 || sec_tick !== 1'b0 || prescale_o !== 3'd0 ||
          timer_expired !== 1'b0)
        $display("FAIL held_load cyc %0d: out=%0d tick=%b pre=%0d exp=%b, want 15 0 0 0",
                 i, timer_out, sec_tick, prescale_o, timer_expired);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(0, 1, 0, 4'd1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 4'd0);
    tick(1, 0, 1, 4'd0);
    n_checks++;
    if (timer_out !== 4'd0 || timer_expired !== 1'b0 || sec_tick !== 1'b0 ||
        state_o !== TMR_IDLE)
      $display("FAIL reset_mid: out=%0d exp=%b tick=%b st=%0d, want 0 0 0 IDLE",
               timer_out, timer_expired, sec_tick, state_o);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 1, 4'd7);
      n_checks++;
      if (timer_expired !== 1'b0 || timer_out !== 4'd0 || state_o !== TMR_IDLE)
        $display("FAIL reset_mid_after cyc %0d: out=%0d exp=%b st=%0d", i,
                 timer_out, timer_expired, state_o);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit r, l, e;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 11) == 0);
      e = ($urandom_range(0, 3) != 0);
      tick(r, l, e, 4'($urandom_range(0, 15)));
      n_checks++;
      if (timer_out !== W'(m_secs) || timer_expired !== m_exp || sec_tick !== m_tick ||
          state_o !== model_state() || prescale_o !== PW'(m_elapsed))
        $display("FAIL random cyc %0d: out=%0d exp=%b tick=%b st=%0d pre=%0d, want %0d %b %b %0d %0d",
                 i, timer_out, timer_expired, sec_tick, state_o, prescale_o,
                 m_secs, m_exp, m_tick, model_state(), m_elapsed);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    m_secs = 0; m_elapsed = 0; m_loaded = 0; m_exp = 0; m_tick = 0;
    test_reset();
    test_count();
    test_pause();
    test_load_priority();
    test_load_zero();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
